// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array sequencer: FSM state codes,
// width helpers and the diagonal lane-skew rule.
package systolic_pkg;

    localparam int N_DEF     = 4;
    localparam int K_MAX_DEF = 256;

    // FSM state codes
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CLEAR = 3'd1;
    localparam logic [2:0] ST_FEED  = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_READ  = 3'd4;

    // Width of k_len: must hold values 0..k_max
    function automatic int calc_kw(input int k_max);
        return $clog2(k_max + 1);
    endfunction

    // Width of the wavefront counter: must hold up to k_max+n-2
    function automatic int calc_tw(input int k_max, input int n);
        return $clog2(k_max + 2 * n);
    endfunction

    // Lane `lane` is fed during wavefront t when it has started (t >= lane)
    // and still has operands left (t - lane < k).
    function automatic logic lane_active(input int t, input int lane, input int k);
        return (t >= lane) && (t < lane + k);
    endfunction

endpackage

// File: rtl/systolic_ctrl_skew_gen.sv
// Registered per-lane operand-feed enables with diagonal skew, derived from
// the wavefront counter and the reduction length. Shape-agnostic so other
// mac array sizes can reuse it.
module skew_gen
    import systolic_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int KW = calc_kw(K_MAX_DEF),
    parameter int TW = calc_tw(K_MAX_DEF, N_DEF)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          en,
    input  logic [TW-1:0] t,
    input  logic [KW-1:0] k,
    output logic [N-1:0]  lane_en
);

    logic [N-1:0] lane_s;

    // Decode which lanes are active for the upcoming wavefront
    always_comb begin
        lane_s = '0;
        for (int i = 0; i < N; i++) begin
            if (en) begin
                lane_s[i] = lane_active(int'(t), i, int'(k));
            end else begin
                lane_s[i] = 1'b0;
            end
        end
    end

    // Register the enables so they align with the registered k_idx
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lane_en <= '0;
        end else begin
            lane_en <= lane_s;
        end
    end

endmodule

// File: rtl/systolic_ctrl.sv
// Sequencer for an N x N output-stationary systolic array: clears the
// accumulators, feeds skewed operand wavefronts, drains the pipeline and
// hands out the N result rows over a valid/ready port.
module systolic_ctrl
    import systolic_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int K_MAX = K_MAX_DEF,
    parameter int KW    = calc_kw(K_MAX),
    parameter int TW    = calc_tw(K_MAX, N)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic [KW-1:0]        k_len,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic                 cfg_err,
    output logic                 acc_clr,
    output logic                 acc_en,
    output logic [N-1:0]         lane_en,
    output logic [TW-1:0]        k_idx,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [$clog2(N)-1:0] res_row
);

    localparam int RW = $clog2(N);

    localparam logic [KW-1:0] K_MAX_W    = KW'(K_MAX);
    localparam logic [TW-1:0] N_M2_T     = TW'(N - 2);
    localparam logic [RW-1:0] DRAIN_LAST = RW'(N - 2);
    localparam logic [RW-1:0] ROW_LAST   = RW'(N - 1);

    logic [2:0]    state_r, state_nx_s;
    logic [KW-1:0] k_r, k_nx_s;
    logic [TW-1:0] t_r, t_nx_s;
    logic [RW-1:0] drain_r, drain_nx_s;
    logic [RW-1:0] row_r, row_nx_s;
    logic          done_nx_s;
    logic          cfg_err_nx_s;
    logic [TW-1:0] t_last_s;
    logic          feed_nx_s;
    logic          drain_ph_nx_s;
    logic          read_nx_s;

    // Last wavefront index of the feed phase: K+N-2
    assign t_last_s = TW'(k_r) + N_M2_T;

    // Next-state and next-counter logic; abort overrides everything
    always_comb begin
        state_nx_s   = state_r;
        k_nx_s       = k_r;
        t_nx_s       = t_r;
        drain_nx_s   = drain_r;
        row_nx_s     = row_r;
        done_nx_s    = 1'b0;
        cfg_err_nx_s = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if ((k_len == '0) || (k_len > K_MAX_W)) begin
                        cfg_err_nx_s = 1'b1;
                    end else begin
                        k_nx_s     = k_len;
                        state_nx_s = ST_CLEAR;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                t_nx_s     = '0;
                state_nx_s = ST_FEED;
            end
            ST_FEED: begin
                if (t_r == t_last_s) begin
                    drain_nx_s = '0;
                    state_nx_s = ST_DRAIN;
                end else begin
                    t_nx_s = t_r + TW'(1);
                end
            end
            ST_DRAIN: begin
                if (drain_r == DRAIN_LAST) begin
                    row_nx_s   = '0;
                    state_nx_s = ST_READ;
                end else begin
                    drain_nx_s = drain_r + RW'(1);
                end
            end
            ST_READ: begin
                if (res_ready) begin
                    if (row_r == ROW_LAST) begin
                        row_nx_s   = '0;
                        done_nx_s  = 1'b1;
                        state_nx_s = ST_IDLE;
                    end else begin
                        row_nx_s = row_r + RW'(1);
                    end
                end else begin
                    row_nx_s = row_r;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase

        if (abort && (state_r != ST_IDLE)) begin
            state_nx_s = ST_IDLE;
            t_nx_s     = '0;
            drain_nx_s = '0;
            row_nx_s   = '0;
            done_nx_s  = 1'b0;
        end else begin
            cfg_err_nx_s = cfg_err_nx_s;
        end
    end

    assign feed_nx_s     = (state_nx_s == ST_FEED);
    assign drain_ph_nx_s = (state_nx_s == ST_DRAIN);
    assign read_nx_s     = (state_nx_s == ST_READ);

    // State and counter registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= ST_IDLE;
            k_r     <= '0;
            t_r     <= '0;
            drain_r <= '0;
            row_r   <= '0;
        end else begin
            state_r <= state_nx_s;
            k_r     <= k_nx_s;
            t_r     <= t_nx_s;
            drain_r <= drain_nx_s;
            row_r   <= row_nx_s;
        end
    end

    // Outputs are decoded from the next state so they change together with it
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            cfg_err   <= 1'b0;
            acc_clr   <= 1'b0;
            acc_en    <= 1'b0;
            k_idx     <= '0;
            res_valid <= 1'b0;
            res_row   <= '0;
        end else begin
            busy      <= (state_nx_s != ST_IDLE);
            done      <= done_nx_s;
            cfg_err   <= cfg_err_nx_s;
            acc_clr   <= (state_nx_s == ST_CLEAR);
            acc_en    <= feed_nx_s || drain_ph_nx_s;
            k_idx     <= (feed_nx_s || drain_ph_nx_s) ? t_nx_s : '0;
            res_valid <= read_nx_s;
            res_row   <= read_nx_s ? row_nx_s : '0;
        end
    end

    skew_gen #(
        .N  (N),
        .KW (KW),
        .TW (TW)
    ) u_skew_gen (
        .clk     (clk),
        .rstn    (rstn),
        .en      (feed_nx_s),
        .t       (t_nx_s),
        .k       (k_nx_s),
        .lane_en (lane_en)
    );

endmodule

// File: tb/tb_systolic_ctrl.sv
// Self-checking bench for systolic_ctrl: per-job expected traces are derived
// from phase lengths (1 clear, K+N-1 feed, N-1 drain, N reads) and the
// diagonal skew rule, with randomized ready, stray starts and aborts.
module tb_systolic_ctrl;

    localparam int N     = 4;
    localparam int K_MAX = 256;
    localparam int KW    = $clog2(K_MAX + 1);
    localparam int TW    = $clog2(K_MAX + 2 * N);
    localparam int RW    = $clog2(N);
    localparam int OW    = 5 + N + TW + 1 + RW;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic [KW-1:0] k_len = '0;
    logic          abort = 1'b0;
    logic          busy, done, cfg_err, acc_clr, acc_en, res_valid;
    logic [N-1:0]  lane_en;
    logic [TW-1:0] k_idx;
    logic          res_ready = 1'b0;
    logic [RW-1:0] res_row;

    int checks = 0;
    int passes = 0;

    systolic_ctrl #(.N(N), .K_MAX(K_MAX)) dut (
        .clk(clk), .rstn(rstn), .start(start), .k_len(k_len), .abort(abort),
        .busy(busy), .done(done), .cfg_err(cfg_err), .acc_clr(acc_clr),
        .acc_en(acc_en), .lane_en(lane_en), .k_idx(k_idx),
        .res_valid(res_valid), .res_ready(res_ready), .res_row(res_row)
    );

    always #5 clk = ~clk;

    function automatic logic [OW-1:0] obs_vec();
        return {busy, done, cfg_err, acc_clr, acc_en, lane_en, k_idx, res_valid, res_row};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ready_mode: 0 always ready, 1 random, 2 stall 5 cycles on row 1
    task automatic run_job(input string name, input int k, input int ready_mode,
                           input int abort_c, input bit rand_start);
        int c, row, stall, feed_len, drain_len, t;
        bit fin, aborted, rdy;
        logic e_busy, e_done, e_clr, e_en, e_valid;
        logic [N-1:0] e_lane;
        logic [TW-1:0] e_kidx;
        logic [RW-1:0] e_row;
        logic [OW-1:0] exp_v;
        c = 0; row = 0; stall = 0; fin = 0; aborted = 0;
        feed_len = k + N - 1;
        drain_len = N - 1;
        start = 1'b1;
        k_len = KW'(k);
        while (!fin) begin
            step();
            c++;
            start = 1'b0; abort = 1'b0; res_ready = 1'b0;
            e_busy = 1'b1; e_done = 1'b0; e_clr = 1'b0; e_en = 1'b0; e_valid = 1'b0;
            e_lane = '0; e_kidx = '0; e_row = '0;
            if (aborted) begin
                e_busy = 1'b0; fin = 1;
            end else if (row == N) begin
                e_busy = 1'b0; e_done = 1'b1; fin = 1;
            end else if (c == 1) begin
                e_clr = 1'b1;
            end else if (c <= 1 + feed_len) begin
                t = c - 2;
                e_en = 1'b1;
                e_kidx = TW'(t);
                for (int i = 0; i < N; i++) e_lane[i] = (t >= i) && (t < i + k);
            end else if (c <= 1 + feed_len + drain_len) begin
                e_en = 1'b1;
                e_kidx = TW'(k + N - 2);
            end else begin
                e_valid = 1'b1;
                e_row = RW'(row);
            end
            exp_v = {e_busy, e_done, 1'b0, e_clr, e_en, e_lane, e_kidx, e_valid, e_row};
            checks++;
            if (obs_vec() !== exp_v) begin
                $display("FAIL %s cycle=%0d got=%h expected=%h", name, c, obs_vec(), exp_v);
            end else begin
                passes++;
            end
            if (!fin) begin
                if (c == abort_c) begin
                    abort = 1'b1;
                    aborted = 1;
                end
                if (e_valid) begin
                    case (ready_mode)
                        0: rdy = 1;
                        1: rdy = ($urandom_range(0, 2) != 0);
                        default: begin
                            if (row == 1 && stall < 5) begin
                                rdy = 0; stall++;
                            end else begin
                                rdy = 1;
                            end
                        end
                    endcase
                    res_ready = rdy;
                    if (rdy && !aborted) row++;
                end
                if (rand_start) begin
                    start = $urandom_range(0, 1);
                    k_len = KW'($urandom_range(0, 300));
                end
            end
            if (c > 2000) begin
                $display("FAIL %s timeout cycle=%0d got=%h expected=%h", name, c, obs_vec(), exp_v);
                checks++;
                fin = 1;
            end
        end
        start = 1'b0; abort = 1'b0; res_ready = 1'b0;
        step();
        checks++;
        if (obs_vec() !== '0) begin
            $display("FAIL %s idle_after got=%h expected=0", name, obs_vec());
        end else begin
            passes++;
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (obs_vec() !== '0) $display("FAIL reset got=%h expected=0", obs_vec());
        else passes++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        step();
        checks++;
        if (obs_vec() !== '0) $display("FAIL reset_release got=%h expected=0", obs_vec());
        else passes++;
    endtask

    task automatic test_basic();
        run_job("basic_k8", 8, 0, -1, 0);
    endtask

    task automatic test_backpressure();
        run_job("backpressure_k2", 2, 2, -1, 0);
    endtask

    task automatic test_cfg_err();
        int bad[2];
        bad[0] = 0;
        bad[1] = K_MAX + 1;
        foreach (bad[j]) begin
            start = 1'b1;
            k_len = KW'(bad[j]);
            step();
            start = 1'b0;
            checks++;
            if (!(cfg_err === 1'b1 && busy === 1'b0 && acc_en === 1'b0))
                $display("FAIL cfg_err_pulse k=%0d got cfg_err=%b busy=%b acc_en=%b expected 1 0 0",
                         bad[j], cfg_err, busy, acc_en);
            else passes++;
            step();
            checks++;
            if (obs_vec() !== '0) $display("FAIL cfg_err_after k=%0d got=%h expected=0", bad[j], obs_vec());
            else passes++;
        end
    endtask

    task automatic test_abort();
        run_job("abort_feed_t4", 8, 0, 6, 0);
        run_job("after_abort_k3", 3, 0, -1, 0);
    endtask

    task automatic test_reset_mid_drain();
        start = 1'b1;
        k_len = KW'(5);
        repeat (10) begin
            step();
            start = 1'b0;
        end
        checks++;
        if (!(acc_en === 1'b1 && lane_en === '0 && k_idx === TW'(7)))
            $display("FAIL drain_entry got acc_en=%b lane_en=%b k_idx=%0d expected 1 0000 7",
                     acc_en, lane_en, k_idx);
        else passes++;
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if (obs_vec() !== '0) $display("FAIL async_reset got=%h expected=0", obs_vec());
        else passes++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        step();
        checks++;
        if (obs_vec() !== '0) $display("FAIL reset_mid_drain_idle got=%h expected=0", obs_vec());
        else passes++;
        run_job("second_job_stray_start", 6, 1, -1, 1);
    endtask

    task automatic test_k1();
        run_job("edge_k1", 1, 0, -1, 0);
    endtask

    task automatic test_kmax();
        run_job("edge_kmax", K_MAX, 1, -1, 1);
    endtask

    task automatic test_random();
        int k, ac;
        for (int j = 0; j < 8; j++) begin
            k = $urandom_range(1, 20);
            ac = ($urandom_range(0, 2) == 0) ? $urandom_range(1, k + 2 * N + 2) : -1;
            run_job("random_job", k, 1, ac, 1);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_cfg_err();
        test_abort();
        test_reset_mid_drain();
        test_k1();
        test_kmax();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
